// File: rtl/rf_wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_queue_if
// Description : Bundle of the write-back queue's handshake, RF write and
//               bypass lookup signals.
//               slave  : the queue side (accepts requests, drives the RF)
//               master : the pipeline/RF side
//   in_valid/in_ready/in_wa/in_wd      write-back request handshake
//   rf_we/rf_wa/rf_wd/rf_ready         RF write port with backpressure
//   ra1/byp1_hit/byp1_data             bypass lookup port 1 (rs)
//   ra2/byp2_hit/byp2_data             bypass lookup port 2 (rt)
//   count/empty/full                   occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_queue_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_wa;
    logic [DW-1:0] in_wd;

    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          rf_ready;

    logic [AW-1:0] ra1;
    logic          byp1_hit;
    logic [DW-1:0] byp1_data;
    logic [AW-1:0] ra2;
    logic          byp2_hit;
    logic [DW-1:0] byp2_data;

    logic [AW-1:0] count;
    logic          empty;
    logic          full;

    modport slave (
        input  in_valid, in_wa, in_wd, rf_ready, ra1, ra2,
        output in_ready, rf_we, rf_wa, rf_wd,
               byp1_hit, byp1_data, byp2_hit, byp2_data,
               count, empty, full
    );

    modport master (
        output in_valid, in_wa, in_wd, rf_ready, ra1, ra2,
        input  in_ready, rf_we, rf_wa, rf_wd,
               byp1_hit, byp1_data, byp2_hit, byp2_data,
               count, empty, full
    );
endinterface
`default_nettype wire

// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_queue
// Description : Write-back queue between MEM/WB and the register file write
//               port. Buffers up to DEPTH register writes, drains them in
//               push order one per cycle under RF backpressure, and offers two
//               combinational bypass lookups over the queued entries.
// Ports       : clk   - rising-edge clock
//               rstn  - synchronous active-low reset
//               bus   - rf_wb_queue_if.slave (request, RF port, bypass, status)
// Parameters  : DEPTH - entries (power of two, >= 2)
//               AW    - register address width (>= log2(DEPTH)+1)
//               DW    - register data width
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    rf_wb_queue_if.slave    bus
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    // Entry storage. Data/address are not reset; the valid bits are what
    // define queue contents.
    logic [AW-1:0]    r_wa [DEPTH];
    logic [DW-1:0]    r_wd [DEPTH];
    logic [DEPTH-1:0] r_vld;

    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_CW-1:0]  r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_enq;
    logic             w_pop;

    logic [c_PW-1:0]  w_idx;
    logic             w_hit1;
    logic [DW-1:0]    w_data1;
    logic             w_hit2;
    logic [DW-1:0]    w_data2;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready depends only on stored occupancy, so a full queue refuses a
    // push even in a cycle where the head is being retired.
    assign w_push  = bus.in_valid && !w_full;
    // r0 writes complete the handshake but never occupy an entry.
    assign w_enq   = w_push && (bus.in_wa != '0);
    assign w_pop   = !w_empty && bus.rf_ready;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wa[r_wr_ptr] <= bus.in_wa;
            r_wd[r_wr_ptr] <= bus.in_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + c_PW'(1);
            end
            // Enqueue only happens when not full, so the write slot is never
            // the head slot being retired in the same cycle.
            if (w_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + c_PW'(1);
            end
            r_count <= r_count + c_CW'(w_enq) - c_CW'(w_pop);
        end
    end

    // Walk entries from oldest (rd_ptr) to youngest; a later match overrides
    // an earlier one, so the youngest matching entry wins.
    always_comb begin
        w_idx   = '0;
        w_hit1  = 1'b0;
        w_data1 = '0;
        w_hit2  = 1'b0;
        w_data2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_rd_ptr + c_PW'(i);
            if (r_vld[w_idx] && (bus.ra1 != '0) && (r_wa[w_idx] == bus.ra1)) begin
                w_hit1  = 1'b1;
                w_data1 = r_wd[w_idx];
            end
            if (r_vld[w_idx] && (bus.ra2 != '0) && (r_wa[w_idx] == bus.ra2)) begin
                w_hit2  = 1'b1;
                w_data2 = r_wd[w_idx];
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.rf_we     = !w_empty;
    assign bus.rf_wa     = r_wa[r_rd_ptr];
    assign bus.rf_wd     = r_wd[r_rd_ptr];
    assign bus.byp1_hit  = w_hit1;
    assign bus.byp1_data = w_data1;
    assign bus.byp2_hit  = w_hit2;
    assign bus.byp2_data = w_data2;
    assign bus.count     = AW'(r_count);
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_wb_queue
// Description : Self-checking bench for rf_wb_queue. A queue-based model of
//               pending writes predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct packed {
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    rf_wb_queue_if #(.AW(AW), .DW(DW)) bus ();

    rf_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    ent_t mq[$];
    bit   known = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest queued entry matching ra; ra==0 never matches.
    task automatic model_byp(input logic [AW-1:0] ra, output logic hit, output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
        if (ra != '0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].wa == ra) begin
                    hit  = 1'b1;
                    data = mq[i].wd;
                end
            end
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, check all outputs
    // shortly after, then advance the model at the rising edge.
    task automatic cyc(input logic v, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rdy, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic rn);
        logic          h;
        logic [DW-1:0] d;
        bit            acc;
        bit            pop;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_wa    = wa;
        bus.in_wd    = wd;
        bus.rf_ready = rdy;
        bus.ra1      = a1;
        bus.ra2      = a2;
        rstn         = rn;
        #1;
        if (known) begin
            chk("count",    64'(bus.count),    64'(mq.size()));
            chk("empty",    64'(bus.empty),    64'(mq.size() == 0));
            chk("full",     64'(bus.full),     64'(mq.size() == DEPTH));
            chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < DEPTH));
            chk("rf_we",    64'(bus.rf_we),    64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rf_wa", 64'(bus.rf_wa), 64'(mq[0].wa));
                chk("rf_wd", 64'(bus.rf_wd), 64'(mq[0].wd));
            end
            model_byp(a1, h, d);
            chk("byp1_hit",  64'(bus.byp1_hit),  64'(h));
            chk("byp1_data", 64'(bus.byp1_data), 64'(d));
            model_byp(a2, h, d);
            chk("byp2_hit",  64'(bus.byp2_hit),  64'(h));
            chk("byp2_data", 64'(bus.byp2_data), 64'(d));
        end
        @(posedge clk);
        if (!rn) begin
            mq.delete();
            known = 1'b1;
        end else if (known) begin
            acc = v && (mq.size() < DEPTH);
            pop = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (acc && wa != '0) mq.push_back('{wa: wa, wd: wd});
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, '0, '0, rdy, '0, '0, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_wa    = '0;
        bus.in_wd    = '0;
        bus.rf_ready = 1'b0;
        bus.ra1      = '0;
        bus.ra2      = '0;

        // Reset held 2 cycles while a request is presented.
        cyc(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, '0, 1'b0);
        cyc(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd7, '0, 1'b0);
        idle(1'b1);
        chk("reset_count", 64'(bus.count), 64'd0);
        chk("reset_rf_we", 64'(bus.rf_we), 64'd0);

        // Single write, then drain.
        cyc(1'b1, 5'd3, 32'h1234_5678, 1'b1, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 5'd3, '0, 1'b1);
        idle(1'b1);
        chk("single_empty", 64'(bus.empty), 64'd1);

        // Fill under backpressure; a 5th push is held until space appears.
        for (int i = 1; i <= 4; i++) cyc(1'b1, AW'(i), 32'hF000_0000 + DW'(i), 1'b0, '0, '0, 1'b1);
        cyc(1'b1, 5'd9, 32'h0000_0009, 1'b0, 5'd2, 5'd4, 1'b1);
        chk("fill_full", 64'(bus.full), 64'd1);
        for (int i = 0; i < 6; i++) cyc(1'b1, 5'd9, 32'h0000_0009, 1'b1, 5'd9, 5'd1, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Youngest-match bypass priority.
        cyc(1'b1, 5'd5, 32'h0000_000A, 1'b0, 5'd5, 5'd6, 1'b1);
        cyc(1'b1, 5'd5, 32'h0000_000B, 1'b0, 5'd5, 5'd6, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 5'd5, 5'd6, 1'b1);
        chk("prio_data", 64'(bus.byp1_data), 64'h0000_000B);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // r0 request is accepted but discarded.
        cyc(1'b1, 5'd0, 32'h0000_DEAD, 1'b1, 5'd0, 5'd0, 1'b1);
        cyc(1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 1'b1);
        chk("r0_count", 64'(bus.count), 64'd0);

        // Mixed writes with random backpressure, wrapping the pointers.
        for (int i = 0; i < 14; i++)
            cyc(1'b1, AW'(1 + i % 7), $urandom, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), 1'b1);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Reset with 3 queued: nothing may reach the RF afterwards.
        for (int i = 0; i < 3; i++) cyc(1'b1, AW'(10 + i), $urandom, 1'b0, '0, '0, 1'b1);
        cyc(1'b0, '0, '0, 1'b0, 5'd10, 5'd12, 1'b1);
        chk("pre_reset_count", 64'(bus.count), 64'd3);
        cyc(1'b0, '0, '0, 1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 5'd10, 5'd11, 1'b1);
        chk("post_reset_rf_we", 64'(bus.rf_we), 64'd0);

        // Randomized traffic with small address range to exercise bypass hits.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                1'($urandom_range(0, 49) != 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
